// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light controller and its protocol monitor:
// lamp codes, phase encodings, fault codes and the monitor state type.
package traffic_pkg;

  localparam logic [3:0] LAMP_G = 4'b0001;
  localparam logic [3:0] LAMP_Y = 4'b0010;
  localparam logic [3:0] LAMP_R = 4'b0100;

  localparam logic [1:0] PH_NS_GREEN  = 2'd0;
  localparam logic [1:0] PH_NS_YELLOW = 2'd1;
  localparam logic [1:0] PH_EW_GREEN  = 2'd2;
  localparam logic [1:0] PH_EW_YELLOW = 2'd3;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_INVALID      = 3'd1;
  localparam logic [2:0] FC_CONFLICT     = 3'd2;
  localparam logic [2:0] FC_ALL_RED      = 3'd3;
  localparam logic [2:0] FC_SEQUENCE     = 3'd4;
  localparam logic [2:0] FC_SHORT_GREEN  = 3'd5;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd6;
  localparam logic [2:0] FC_LONG_YELLOW  = 3'd7;

  typedef enum logic [1:0] {
    MON_UNSYNC = 2'd0,
    MON_TRACK  = 2'd1,
    MON_FAULT  = 2'd2
  } mon_state_t;

  typedef struct packed {
    logic g;
    logic y;
    logic r;
    logic inv;
  } lamp_dec_t;

  // Odd phase encodings are the yellow phases.
  function automatic logic is_yellow_phase(input logic [1:0] ph);
    return ph[0];
  endfunction

endpackage

// File: rtl/lamp_decode.sv
// Decodes one direction's 4-bit lamp code into one-hot {G,Y,R,INV}.
// Any code other than exactly G, Y or R (bit 3 clear) is INV.
module lamp_decode
  import traffic_pkg::*;
(
  input  logic [3:0] code,
  output lamp_dec_t  dec
);

  always_comb begin
    dec = '0;
    case (code)
      LAMP_G:  dec.g   = 1'b1;
      LAMP_Y:  dec.y   = 1'b1;
      LAMP_R:  dec.r   = 1'b1;
      default: dec.inv = 1'b1;
    endcase
  end

endmodule

// File: rtl/traffic_monitor.sv
// Safety/protocol monitor on the NS/EW lamp buses: decodes lamps into phases,
// tracks phase order and dwell times, and latches the first violation.
//
// state      | meaning
// MON_UNSYNC | waiting for the first legal phase to lock onto
// MON_TRACK  | locked; checking phase order and dwell limits
// MON_FAULT  | first fault latched; phase/cycles frozen until clr_fault
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int GMIN = 10000,
  parameter int YMIN = 1500,
  parameter int YMAX = 3000,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    NS,
  input  logic [3:0]    EW,
  input  logic          clr_fault,
  output logic          fault,
  output logic [2:0]    fault_code,
  output logic [1:0]    phase,
  output logic          locked,
  output logic [CW-1:0] cycles
);

  localparam logic [CW-1:0] GMIN_C    = CW'(GMIN);
  localparam logic [CW-1:0] YMIN_C    = CW'(YMIN);
  localparam logic [CW-1:0] YMAX_C    = CW'(YMAX);
  localparam logic [CW-1:0] DWELL_MAX = {CW{1'b1}};

  mon_state_t    state;
  logic [CW-1:0] dwell;
  logic          first_phase;

  lamp_dec_t     ns_dec;
  lamp_dec_t     ew_dec;
  logic [2:0]    lamp_code;
  logic [2:0]    track_code;
  logic [1:0]    obs_phase;
  logic [1:0]    succ_phase;
  logic          min_met;

  lamp_decode u_ns_decode (
    .code (NS),
    .dec  (ns_dec)
  );

  lamp_decode u_ew_decode (
    .code (EW),
    .dec  (ew_dec)
  );

  // Lamp-level violations, highest priority first.
  always_comb begin
    lamp_code = FC_NONE;
    if (ns_dec.inv || ew_dec.inv) begin
      lamp_code = FC_INVALID;
    end else if (!ns_dec.r && !ew_dec.r) begin
      lamp_code = FC_CONFLICT;
    end else if (ns_dec.r && ew_dec.r) begin
      lamp_code = FC_ALL_RED;
    end
  end

  // Only meaningful when lamp_code is FC_NONE: exactly one side is red.
  always_comb begin
    obs_phase = PH_NS_GREEN;
    if (ns_dec.g) begin
      obs_phase = PH_NS_GREEN;
    end else if (ns_dec.y) begin
      obs_phase = PH_NS_YELLOW;
    end else if (ew_dec.g) begin
      obs_phase = PH_EW_GREEN;
    end else if (ew_dec.y) begin
      obs_phase = PH_EW_YELLOW;
    end
  end

  assign succ_phase = phase + 2'd1;
  assign min_met    = is_yellow_phase(phase) ? (dwell >= YMIN_C) : (dwell >= GMIN_C);

  always_comb begin
    track_code = lamp_code;
    if (lamp_code == FC_NONE) begin
      if (obs_phase == phase) begin
        if (is_yellow_phase(phase) && (dwell == YMAX_C)) begin
          track_code = FC_LONG_YELLOW;
        end
      end else if (obs_phase == succ_phase) begin
        // The phase seen at sync is partial, so its minimum is not enforced.
        if (!first_phase && !min_met) begin
          track_code = is_yellow_phase(phase) ? FC_SHORT_YELLOW : FC_SHORT_GREEN;
        end
      end else begin
        track_code = FC_SEQUENCE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= MON_UNSYNC;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      phase       <= PH_NS_GREEN;
      locked      <= 1'b0;
      cycles      <= '0;
      dwell       <= '0;
      first_phase <= 1'b0;
    end else begin
      case (state)
        MON_UNSYNC: begin
          if (lamp_code != FC_NONE) begin
            state      <= MON_FAULT;
            fault      <= 1'b1;
            fault_code <= lamp_code;
            locked     <= 1'b0;
          end else begin
            state       <= MON_TRACK;
            phase       <= obs_phase;
            dwell       <= CW'(1);
            first_phase <= 1'b1;
            locked      <= 1'b1;
          end
        end
        MON_TRACK: begin
          if (track_code != FC_NONE) begin
            state      <= MON_FAULT;
            fault      <= 1'b1;
            fault_code <= track_code;
            locked     <= 1'b0;
          end else if (obs_phase == phase) begin
            if (dwell != DWELL_MAX) begin
              dwell <= dwell + CW'(1);
            end
          end else begin
            phase       <= succ_phase;
            dwell       <= CW'(1);
            first_phase <= 1'b0;
            if (succ_phase == PH_NS_GREEN) begin
              cycles <= cycles + CW'(1);
            end
          end
        end
        MON_FAULT: begin
          if (clr_fault) begin
            state      <= MON_UNSYNC;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
          end
        end
        default: begin
          state  <= MON_UNSYNC;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_monitor.sv
// Self-checking bench for traffic_monitor: directed test-plan scenarios plus
// randomized lamp traffic checked against a behavioural model.
module tb_traffic_monitor;
  import traffic_pkg::*;

  localparam int GMIN = 4;
  localparam int YMIN = 2;
  localparam int YMAX = 3;
  localparam int CW   = 4;
  localparam int DMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    ns_i = 4'b0100;
  logic [3:0]    ew_i = 4'b0100;
  logic          clr_i = 1'b0;
  logic          fault;
  logic [2:0]    fault_code;
  logic [1:0]    phase;
  logic          locked;
  logic [CW-1:0] cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit m_synced, m_faulted, m_first;
  int m_code, m_phase, m_cycles, m_dwell;

  traffic_monitor #(.GMIN(GMIN), .YMIN(YMIN), .YMAX(YMAX), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .NS         (ns_i),
    .EW         (ew_i),
    .clr_fault  (clr_i),
    .fault      (fault),
    .fault_code (fault_code),
    .phase      (phase),
    .locked     (locked),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // 0=G 1=Y 2=R 3=invalid
  function automatic int lamp_class(input logic [3:0] c);
    if (c == 4'b0001) return 0;
    if (c == 4'b0010) return 1;
    if (c == 4'b0100) return 2;
    return 3;
  endfunction

  function automatic logic [7:0] lamps_for(input int p);
    case (p)
      0:       return {LAMP_G, LAMP_R};
      1:       return {LAMP_Y, LAMP_R};
      2:       return {LAMP_R, LAMP_G};
      default: return {LAMP_R, LAMP_Y};
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [3:0] n, input logic [3:0] e, input logic c);
    int cn, ce, obs, viol;
    if (!r) begin
      m_synced = 0; m_faulted = 0; m_first = 0;
      m_code = 0; m_phase = 0; m_cycles = 0; m_dwell = 0;
      return;
    end
    if (m_faulted) begin
      if (c) begin
        m_faulted = 0; m_code = 0; m_synced = 0;
      end
      return;
    end
    cn = lamp_class(n);
    ce = lamp_class(e);
    viol = 0;
    if (cn == 3 || ce == 3) viol = 1;
    else if (cn != 2 && ce != 2) viol = 2;
    else if (cn == 2 && ce == 2) viol = 3;
    obs = (cn == 2) ? 2 + ce : cn;
    if (viol == 0 && !m_synced) begin
      m_synced = 1; m_phase = obs; m_dwell = 1; m_first = 1;
      return;
    end
    if (viol == 0) begin
      if (obs == m_phase) begin
        if (m_phase % 2 == 1 && m_dwell == YMAX) viol = 7;
        else if (m_dwell < DMAX) m_dwell++;
      end else if (obs == (m_phase + 1) % 4) begin
        if (m_first || m_dwell >= ((m_phase % 2 == 1) ? YMIN : GMIN)) begin
          m_phase = obs; m_dwell = 1; m_first = 0;
          if (obs == 0) m_cycles = (m_cycles + 1) % (DMAX + 1);
        end else begin
          viol = (m_phase % 2 == 1) ? 6 : 5;
        end
      end else begin
        viol = 4;
      end
    end
    if (viol != 0) begin
      m_faulted = 1; m_code = viol;
    end
  endtask

  task automatic check_outputs();
    chk("fault",      fault,      m_faulted);
    chk("fault_code", fault_code, m_code);
    chk("phase",      phase,      m_faulted ? m_phase : (m_synced ? m_phase : m_phase));
    chk("locked",     locked,     m_synced && !m_faulted);
    chk("cycles",     cycles,     m_cycles);
  endtask

  task automatic cyc(input logic [3:0] n, input logic [3:0] e, input logic c);
    ns_i = n; ew_i = e; clr_i = c;
    @(posedge clk);
    model_step(rst, n, e, c);
    #1;
    check_outputs();
    clr_i = 1'b0;
  endtask

  task automatic hold(input int p, input int len);
    logic [7:0] l;
    l = lamps_for(p);
    for (int i = 0; i < len; i++) cyc(l[7:4], l[3:0], 1'b0);
  endtask

  task automatic clear();
    cyc(LAMP_G, LAMP_R, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(LAMP_R, LAMP_R, 1'b0);
    rst = 1'b1;
  endtask

  initial begin
    int dp, len;
    logic [7:0] l;

    do_reset();
    chk("rst_fault",  fault, 1'b0);
    chk("rst_code",   fault_code, 3'd0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_cycles", cycles, 0);

    // legal sequence
    hold(0, 1);
    chk("legal_lock", locked, 1'b1);
    hold(0, 4); hold(1, 2); hold(2, 4); hold(3, 3); hold(0, 1);
    chk("legal_phase",  phase, 2'd0);
    chk("legal_cycles", cycles, 1);
    chk("legal_fault",  fault, 1'b0);

    // conflict then clear
    cyc(4'b0001, 4'b0001, 1'b0);
    chk("conflict_code",   fault_code, 3'd2);
    chk("conflict_locked", locked, 1'b0);
    clear();
    chk("clear_fault", fault, 1'b0);
    chk("clear_code",  fault_code, 3'd0);
    hold(0, 1);
    chk("relock", locked, 1'b1);

    // invalid / all-red / priority
    cyc(4'b1001, LAMP_R, 1'b0);
    chk("inv_bit3", fault_code, 3'd1);
    clear();
    cyc(4'b0011, LAMP_R, 1'b0);
    chk("inv_multi", fault_code, 3'd1);
    clear();
    cyc(LAMP_R, LAMP_R, 1'b0);
    chk("all_red", fault_code, 3'd3);
    clear();
    cyc(4'b0011, 4'b0001, 1'b0);
    chk("inv_prio", fault_code, 3'd1);

    // clear wins over a same-cycle violation, then re-detected
    cyc(4'b0001, 4'b0001, 1'b1);
    chk("clr_wins", fault, 1'b0);
    cyc(4'b0001, 4'b0001, 1'b0);
    chk("redetect", fault_code, 3'd2);

    // short green
    clear();
    hold(0, 1); hold(1, 2); hold(2, 3); hold(3, 1);
    chk("short_green", fault_code, 3'd5);
    // short yellow
    clear();
    hold(0, 1); hold(1, 2); hold(2, 4); hold(3, 1); hold(0, 1);
    chk("short_yellow", fault_code, 3'd6);
    // sequence
    clear();
    hold(0, 1); hold(2, 1);
    chk("sequence", fault_code, 3'd4);
    // long yellow, sticky code
    clear();
    hold(1, 3);
    chk("ly_pre", fault, 1'b0);
    hold(1, 1);
    chk("long_yellow", fault_code, 3'd7);
    cyc(4'b0001, 4'b0001, 1'b0);
    chk("sticky_code", fault_code, 3'd7);

    // reset mid-fault with cycles=3
    do_reset();
    hold(0, 1);
    for (int k = 0; k < 3; k++) begin
      hold(1, 2); hold(2, 4); hold(3, 2); hold(0, 4);
    end
    cyc(4'b1111, LAMP_R, 1'b0);
    chk("mf_cycles", cycles, 3);
    chk("mf_fault",  fault, 1'b1);
    do_reset();
    chk("mf_rst_fault",  fault, 1'b0);
    chk("mf_rst_code",   fault_code, 3'd0);
    chk("mf_rst_phase",  phase, 2'd0);
    chk("mf_rst_locked", locked, 1'b0);
    chk("mf_rst_cycles", cycles, 0);
    chk("mf_rst_state",  dut.state, MON_UNSYNC);

    // randomized traffic
    dp = 0;
    for (int s = 0; s < 1500; s++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      end else if (r < 14) begin
        l = lamps_for(dp);
        cyc(l[7:4], l[3:0], 1'b1);
      end else if (r < 16) begin
        do_reset();
      end else begin
        dp = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : (dp + 1) % 4;
        len = (dp % 2 == 1) ? $urandom_range(1, YMAX + 1) : $urandom_range(GMIN - 2, GMIN + 3);
        l = lamps_for(dp);
        for (int i = 0; i < len; i++) cyc(l[7:4], l[3:0], $urandom_range(0, 19) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
